acc_feeder: RTL

- Producer/checker at the input end of acc_core's number-stream interface.
- On a start command it drives run/valid/number into acc_core: start_val, start_val+1, … for `count` beats.
- It then waits for the core's valid result and captures it.
- It compares the result against an internally accumulated expected sum, so acc_core runs self-checked in system tests and on the FPGA.

---
 rtl/acc_pkg.sv | 17 +
 rtl/acc_expect.sv | 33 +++
 rtl/acc_feeder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared state encoding and default widths for the acc_feeder / acc_core pair
package acc_pkg;

    // Default widths shared with acc_core so both ends of the number stream agree.
    localparam int ACC_IN_DATA_WIDTH = 8;
    localparam int ACC_DWIDTH        = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/acc_expect.sv
// rtl/acc_expect.sv - running expected-sum register for the number stream
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero the sum (wins over en)
//   en         : add zero-extended data into the sum this cycle
//   data       : number being accumulated
//   sum        : DWIDTH-bit running sum, wraps mod 2^DWIDTH
module acc_expect
    import acc_pkg::*;
#(
    parameter int DATA_WIDTH = ACC_IN_DATA_WIDTH,
    parameter int DWIDTH     = ACC_DWIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DWIDTH-1:0]     sum
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + DWIDTH'(data);
        end
    end

endmodule

// File: rtl/acc_feeder.sv
// rtl/acc_feeder.sv - stimulus producer and result checker in front of acc_core
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start_i         : start request, honoured only in IDLE
//   start_val_i     : first number of the sequence
//   count_i         : number of beats to send (0 allowed)
//   number_o        : data beat to acc_core
//   valid_o, run_o  : beat qualifier and run window to acc_core
//   core_valid_i    : acc_core result valid
//   core_result_i   : acc_core result
//   busy_o          : high outside IDLE
//   done_o          : one-cycle pulse at the end of every run
//   result_o        : captured core result
//   match_o         : captured result equalled the expected sum
//   timeout_o       : last run ended without a core result
module acc_feeder
    import acc_pkg::*;
#(
    parameter int IN_DATA_WIDTH = ACC_IN_DATA_WIDTH,
    parameter int DWIDTH        = ACC_DWIDTH,
    parameter int TIMEOUT       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [IN_DATA_WIDTH-1:0] start_val_i,
    input  logic [IN_DATA_WIDTH-1:0] count_i,
    output logic [IN_DATA_WIDTH-1:0] number_o,
    output logic                     valid_o,
    output logic                     run_o,
    input  logic                     core_valid_i,
    input  logic [DWIDTH-1:0]        core_result_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [DWIDTH-1:0]        result_o,
    output logic                     match_o,
    output logic                     timeout_o
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t                   state;
    logic [IN_DATA_WIDTH-1:0] beats;
    logic [TW-1:0]            wait_cnt;
    logic [DWIDTH-1:0]        expected;
    logic                     exp_clr;
    logic                     exp_en;

    // The sum is cleared on the accepted start and fed from the registered
    // number_o, so it tracks exactly the beats that reach the core.
    assign exp_clr = (state == ST_IDLE) && start_i;
    assign exp_en  = (state == ST_FEED);

    acc_expect #(
        .DATA_WIDTH (IN_DATA_WIDTH),
        .DWIDTH     (DWIDTH)
    ) u_expect (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (exp_clr),
        .en    (exp_en),
        .data  (number_o),
        .sum   (expected)
    );

    // Outputs are updated on the transition into a state so that they are
    // registered and line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            beats     <= '0;
            wait_cnt  <= '0;
            number_o  <= '0;
            valid_o   <= 1'b0;
            run_o     <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            result_o  <= '0;
            match_o   <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        number_o <= start_val_i;
                        beats    <= count_i;
                        run_o    <= 1'b1;
                        busy_o   <= 1'b1;
                        state    <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (beats != '0) begin
                        valid_o <= 1'b1;
                        state   <= ST_FEED;
                    end else begin
                        state   <= ST_DRAIN;
                    end
                end
                ST_FEED: begin
                    // number_o is left on the last beat so DRAIN holds it.
                    if (beats == IN_DATA_WIDTH'(1)) begin
                        valid_o <= 1'b0;
                        state   <= ST_DRAIN;
                    end else begin
                        number_o <= number_o + 1'b1;
                        beats    <= beats - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    run_o    <= 1'b0;
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_valid_i) begin
                        result_o  <= core_result_i;
                        match_o   <= (core_result_i == expected);
                        timeout_o <= 1'b0;
                        done_o    <= 1'b1;
                        state     <= ST_DONE;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        timeout_o <= 1'b1;
                        match_o   <= 1'b0;
                        done_o    <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
